// File: rtl/edp_mdu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : edp_mdu_pkg
//  Description : Shared types for the EBOX multiply/divide unit: controller
//                state encoding, operation encoding and op decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package edp_mdu_pkg;

   // Controller states; DONE is a single-cycle result strobe state
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   // Operation encoding as presented on the op port
   typedef enum logic [1:0] {
      OP_MULU = 2'b00,
      OP_MULS = 2'b01,
      OP_DIVU = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   // The reserved code executes as this operation
   localparam op_e OP_RSVD_DEFAULT = OP_MULU;

   // Map the raw op field to the operation actually executed. When the
   // divide path is not built, a divide request degrades to unsigned multiply.
   function automatic op_e decode_op(input logic [1:0] raw, input logic div_en);
      op_e res;
      case (raw)
         2'b00:   res = OP_MULU;
         2'b01:   res = OP_MULS;
         2'b10:   res = div_en ? OP_DIVU : OP_MULU;
         default: res = OP_RSVD_DEFAULT;
      endcase
      return res;
   endfunction

endpackage
`default_nettype wire

// File: rtl/edp_mdu_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : edp_mdu_addsub
//  Description : N-bit adder/subtractor with carry-out. Subtraction is
//                performed as a + ~b + 1, so co_o is the inverted borrow.
//  Revision    : 1.0 - initial release
// ============================================================================
module edp_mdu_addsub #(
   parameter int N = 37
) (
   input  logic [N-1:0] a_i,
   input  logic [N-1:0] b_i,
   input  logic         sub_i,
   output logic [N-1:0] s_o,
   output logic         co_o
);

   logic [N-1:0] b_x;

   // Conditionally complement the second operand; sub_i doubles as carry-in
   assign b_x = sub_i ? ~b_i : b_i;

   assign {co_o, s_o} = {1'b0, a_i} + {1'b0, b_x} + {{N{1'b0}}, sub_i};

endmodule
`default_nettype wire

// File: rtl/edp_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : edp_mdu
//  Description : Iterative EBOX multiply/divide unit. One shift/add
//                (multiply) or shift/subtract (non-restoring divide) step per
//                clock, sharing a single W+1-bit adder and one 2W+1-bit
//                partial product / partial remainder register.
//                Optional divide path: define EDP_MDU_DIV_EN to build it
//                (FIX state, no-divide detection). Without it, op=10 runs as
//                an unsigned multiply and ndv stays 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module edp_mdu
   import edp_mdu_pkg::*;
#(
   parameter int W  = 36,
   parameter int CW = $clog2(W + 1)
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [W-1:0] a_hi,
   input  logic [W-1:0] a_lo,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] hi,
   output logic [W-1:0] lo,
   output logic         ndv
);

`ifdef EDP_MDU_DIV_EN
   localparam logic C_DIV_EN = 1'b1;
`else
   localparam logic C_DIV_EN = 1'b0;
`endif

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   state_e        state_q;
   op_e           op_q;        // operation latched at start
   logic [CW-1:0] cnt_q;       // remaining RUN steps
   logic [W-1:0]  opnd_q;      // multiplicand (multiply) or divisor (divide)
   logic          busy_q;
   logic          done_q;
   logic          ndv_q;

   // Layout of p_q:
   //   multiply : {partial product high (W+1, signed for op=01), multiplier/product low (W)}
   //   divide   : {partial remainder (W+1, two's complement), dividend low/quotient (W)}
   logic [2*W:0]  p_q;
   logic [2*W:0]  p_d;

   // ------------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------------
   op_e           op_sel;
   logic          no_div;
   logic          last_step;
   logic [W:0]    add_a;
   logic [W:0]    add_b;
   logic [W:0]    add_s;
   logic          add_sub;
   logic          add_co;
   logic [W:0]    mul_sum;
   logic          mul_ext;

   assign op_sel    = decode_op(op, C_DIV_EN);
   assign last_step = (cnt_q == CW'(1));

`ifdef EDP_MDU_DIV_EN
   // A divide whose quotient cannot fit W bits (or b==0) is refused up front
   assign no_div = (op_sel == OP_DIVU) && ((b == '0) || (a_hi >= b));
`else
   logic unused_a_hi;
   assign no_div      = 1'b0;
   assign unused_a_hi = ^a_hi;
`endif

   // Select adder operands for the current step
   always_comb begin
      add_a   = p_q[2*W:W];
      add_b   = {1'b0, opnd_q};
      add_sub = 1'b0;
      if (op_q == OP_MULS) begin
         // Signed multiply: the multiplier's sign bit carries weight -2^(W-1),
         // so its partial product is subtracted on the final step.
         add_b   = {opnd_q[W-1], opnd_q};
         add_sub = last_step;
      end
`ifdef EDP_MDU_DIV_EN
      if ((state_q == ST_RUN) && (op_q == OP_DIVU)) begin
         // Shift remainder left, pulling in the next dividend bit; subtract
         // when the remainder is non-negative, add back when negative.
         add_a   = {p_q[2*W-1:W], p_q[W-1]};
         add_sub = ~p_q[2*W];
      end
      // FIX uses the defaults: remainder + {0, divisor}
`endif
   end

   edp_mdu_addsub #(
      .N (W + 1)
   ) u_addsub (
      .a_i   (add_a),
      .b_i   (add_b),
      .sub_i (add_sub),
      .s_o   (add_s),
      .co_o  (add_co)
   );

   // Next value of the partial product / remainder register
   always_comb begin
      p_d     = p_q;
      // Multiply accumulates only when the current multiplier bit is set
      mul_sum = p_q[0] ? add_s : p_q[2*W:W];
      // Bit shifted into the top: sign for signed, carry-out for unsigned
      mul_ext = (op_q == OP_MULS) ? mul_sum[W] : (p_q[0] & add_co);
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               p_d = {{(W + 1){1'b0}}, b};
`ifdef EDP_MDU_DIV_EN
               // Also the hold value for a refused divide: hi/lo = a_hi/a_lo
               if (op_sel == OP_DIVU) begin
                  p_d = {1'b0, a_hi, a_lo};
               end
`endif
            end
         end
         ST_RUN: begin
            p_d = {mul_ext, mul_sum, p_q[W-1:1]};
`ifdef EDP_MDU_DIV_EN
            if (op_q == OP_DIVU) begin
               // Quotient bit is 1 when the new remainder is non-negative
               p_d = {add_s, p_q[W-2:0], ~add_s[W]};
            end
`endif
         end
`ifdef EDP_MDU_DIV_EN
         ST_FIX: begin
            if (p_q[2*W]) begin
               p_d = {add_s, p_q[W-1:0]};
            end
         end
`endif
         default: ;
      endcase
   end

   // Partial product / remainder register, shifted once per step
   always_ff @(posedge clk) begin
      if (reset) begin
         p_q <= '0;
      end else begin
         p_q <= p_d;
      end
   end

   // Controller: state, step counter, operand latch and registered status
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         op_q    <= OP_MULU;
         cnt_q   <= '0;
         opnd_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         ndv_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  op_q   <= op_sel;
                  opnd_q <= (op_sel == OP_DIVU) ? b : a_lo;
                  busy_q <= 1'b1;
                  ndv_q  <= no_div;
                  if (no_div) begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                     cnt_q   <= '0;
                  end else begin
                     state_q <= ST_RUN;
                     cnt_q   <= CW'(W);
                  end
               end
            end
            ST_RUN: begin
               cnt_q <= cnt_q - CW'(1);
               if (last_step) begin
`ifdef EDP_MDU_DIV_EN
                  if (op_q == OP_DIVU) begin
                     state_q <= ST_FIX;
                  end else begin
                     state_q <= ST_DONE;
                     done_q  <= 1'b1;
                  end
`else
                  state_q <= ST_DONE;
                  done_q  <= 1'b1;
`endif
               end
            end
`ifdef EDP_MDU_DIV_EN
            ST_FIX: begin
               state_q <= ST_DONE;
               done_q  <= 1'b1;
            end
`endif
            ST_DONE: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = p_q[2*W-1:W];
   assign lo   = p_q[W-1:0];
   assign ndv  = ndv_q;

endmodule
`default_nettype wire

// File: tb/tb_edp_mdu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_edp_mdu
//  Description : Self-checking bench for edp_mdu. Expected results come from
//                a direct arithmetic model and are queued when an operation
//                is issued, then popped when done pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_edp_mdu;

   localparam int W       = 36;
   localparam int TIMEOUT = 120;

   typedef struct packed {
      logic [W-1:0] hi;
      logic [W-1:0] lo;
      logic         ndv;
      logic [7:0]   lat;
   } exp_t;

   logic         clk;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] a_hi;
   logic [W-1:0] a_lo;
   logic [W-1:0] b;
   logic         busy;
   logic         done;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         ndv;

   int   checks = 0;
   int   errors = 0;
   exp_t sb_q[$];

   edp_mdu #(.W(W)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .a_hi  (a_hi),
      .a_lo  (a_lo),
      .b     (b),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo),
      .ndv   (ndv)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   function automatic logic [W-1:0] rnd();
      logic [63:0] r;
      r = {$urandom(), $urandom()};
      return r[W-1:0];
   endfunction

   // Reference arithmetic: expected hi/lo/ndv and start-to-done latency
   function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] ah,
                                  input logic [W-1:0] al, input logic [W-1:0] bb);
      exp_t                  e;
      logic [1:0]            eo;
      logic [2*W-1:0]        p;
      logic signed [2*W-1:0] sa;
      logic signed [2*W-1:0] sb;
      logic signed [2*W-1:0] sp;
      eo = (o == 2'b11) ? 2'b00 : o;
`ifndef EDP_MDU_DIV_EN
      if (eo == 2'b10) eo = 2'b00;
`endif
      e.ndv = 1'b0;
      e.lat = 8'(W + 1);
      case (eo)
         2'b01: begin
            sa = $signed({{W{al[W-1]}}, al});
            sb = $signed({{W{bb[W-1]}}, bb});
            sp = sa * sb;
            p  = sp;
         end
         2'b10: begin
            if ((bb == '0) || (ah >= bb)) begin
               p     = {ah, al};
               e.ndv = 1'b1;
               e.lat = 8'd1;
            end else begin
               p[W-1:0]   = W'({ah, al} / {{W{1'b0}}, bb});
               p[2*W-1:W] = W'({ah, al} % {{W{1'b0}}, bb});
               e.lat      = 8'(W + 2);
            end
         end
         default: p = {{W{1'b0}}, al} * {{W{1'b0}}, bb};
      endcase
      e.hi = p[2*W-1:W];
      e.lo = p[W-1:0];
      return e;
   endfunction

   // Drive one request, queue its expectation; start is dropped unless held
   task automatic issue(input logic [1:0] o, input logic [W-1:0] ah,
                        input logic [W-1:0] al, input logic [W-1:0] bb, input bit hold);
      sb_q.push_back(model(o, ah, al, bb));
      op    = o;
      a_hi  = ah;
      a_lo  = al;
      b     = bb;
      start = 1'b1;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
   endtask

   // Wait (bounded) for done; lat counts edges including the start edge
   task automatic wait_done(output exp_t obs);
      int n;
      n = 1;
      while ((done !== 1'b1) && (n < TIMEOUT)) begin
         @(posedge clk); #1;
         n++;
      end
      obs.hi  = hi;
      obs.lo  = lo;
      obs.ndv = ndv;
      obs.lat = (done === 1'b1) ? 8'(n) : 8'hFF;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      start = 1'b1;
      op    = 2'b00;
      a_hi  = '0;
      a_lo  = 36'd3;
      b     = 36'd5;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b0;
      start = 1'b0;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
      checks++; if (ndv !== 1'b0) begin errors++; $display("FAIL reset_ndv got %b want 0", ndv); end
      checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi got %h want 0", hi); end
      checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo got %h want 0", lo); end
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored busy got %b want 0", busy); end
   endtask

   task automatic test_mul_unsigned();
      exp_t obs, e;
      logic [W-1:0] al, bb;
      for (int i = 0; i < 6; i++) begin
         al = (i == 0) ? 36'd3 : (i == 1) ? '1 : (i == 2) ? '0 : rnd();
         bb = (i == 0) ? 36'd5 : (i == 1) ? '1 : rnd();
         issue(2'b00, rnd(), al, bb, 1'b0);
         wait_done(obs);
         e = sb_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL mulu[%0d] got hi=%h lo=%h ndv=%b lat=%0d want hi=%h lo=%h ndv=%b lat=%0d",
                     i, obs.hi, obs.lo, obs.ndv, obs.lat, e.hi, e.lo, e.ndv, e.lat);
         end
         if (i == 0) begin
            checks++;
            if ((obs.lo !== 36'd15) || (obs.hi !== '0) || (obs.lat !== 8'd37)) begin
               errors++;
               $display("FAIL mulu_3x5 got hi=%h lo=%h lat=%0d want hi=0 lo=f lat=37", obs.hi, obs.lo, obs.lat);
            end
         end
         checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mulu_busy_at_done got %b want 1", busy); end
         @(posedge clk); #1;
         checks++;
         if ((done !== 1'b0) || (busy !== 1'b0)) begin
            errors++;
            $display("FAIL mulu_done_pulse got done=%b busy=%b want 0 0", done, busy);
         end
      end
   endtask

   task automatic test_mul_signed();
      exp_t obs, e;
      logic [W-1:0] al, bb, mn;
      mn = '0;
      mn[W-1] = 1'b1;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0:       begin al = '1;     bb = '1;     end
            1:       begin al = '1;     bb = 36'd5;  end
            2:       begin al = 36'd7;  bb = -36'sd3; end
            3:       begin al = mn;     bb = mn;     end
            4:       begin al = mn;     bb = '1;     end
            default: begin al = rnd();  bb = rnd();  end
         endcase
         issue(2'b01, rnd(), al, bb, 1'b0);
         wait_done(obs);
         e = sb_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL muls[%0d] got hi=%h lo=%h ndv=%b lat=%0d want hi=%h lo=%h ndv=%b lat=%0d",
                     i, obs.hi, obs.lo, obs.ndv, obs.lat, e.hi, e.lo, e.ndv, e.lat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_divide();
      exp_t obs, e;
      logic [W-1:0] ah, al, bb;
      for (int i = 0; i < 8; i++) begin
         al = rnd();
         bb = rnd();
         if (bb == '0) bb = 36'd1;
         ah = rnd() % bb;
         case (i)
            0: begin ah = '0; al = 36'd100; bb = 36'd7; end
            1: bb = '0;
            2: begin ah = 36'd7; bb = 36'd7; end
            3: ah = bb - 36'd1;
            4: begin ah = bb; ah[0] = 1'b1; ah[W-1] = 1'b1; bb = bb >> 1; end
            default: ;
         endcase
         issue(2'b10, ah, al, bb, 1'b0);
         wait_done(obs);
         e = sb_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL div[%0d] got hi=%h lo=%h ndv=%b lat=%0d want hi=%h lo=%h ndv=%b lat=%0d",
                     i, obs.hi, obs.lo, obs.ndv, obs.lat, e.hi, e.lo, e.ndv, e.lat);
         end
`ifdef EDP_MDU_DIV_EN
         if (i == 0) begin
            checks++;
            if ((obs.lo !== 36'd14) || (obs.hi !== 36'd2) || (obs.ndv !== 1'b0) || (obs.lat !== 8'd38)) begin
               errors++;
               $display("FAIL div_100_7 got hi=%h lo=%h ndv=%b lat=%0d want hi=2 lo=e ndv=0 lat=38",
                        obs.hi, obs.lo, obs.ndv, obs.lat);
            end
         end
`endif
         @(posedge clk); #1;
         checks++;
         if (ndv !== e.ndv) begin errors++; $display("FAIL div_ndv_hold got %b want %b", ndv, e.ndv); end
      end
   endtask

   task automatic test_reserved();
      exp_t obs, e;
      for (int i = 0; i < 2; i++) begin
         issue(2'b11, rnd(), rnd(), rnd(), 1'b0);
         wait_done(obs);
         e = sb_q.pop_front();
         checks++;
         if (obs !== e) begin
            errors++;
            $display("FAIL rsvd[%0d] got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                     i, obs.hi, obs.lo, obs.lat, e.hi, e.lo, e.lat);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_reset_midrun();
      exp_t obs, e;
      bit   saw_done;
      issue(2'b00, '0, rnd(), rnd(), 1'b0);
      void'(sb_q.pop_back());
      saw_done = (done === 1'b1);
      repeat (9) begin
         @(posedge clk); #1;
         if (done === 1'b1) saw_done = 1'b1;
      end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrun_busy got %b want 1", busy); end
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      checks++;
      if ((busy !== 1'b0) || (done !== 1'b0) || saw_done) begin
         errors++;
         $display("FAIL midrun_reset got busy=%b done=%b early_done=%b want 0 0 0", busy, done, saw_done);
      end
      checks++;
      if ((hi !== '0) || (lo !== '0)) begin
         errors++;
         $display("FAIL midrun_reset_result got hi=%h lo=%h want 0 0", hi, lo);
      end
      issue(2'b01, '0, rnd(), rnd(), 1'b0);
      wait_done(obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL midrun_restart got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                  obs.hi, obs.lo, obs.lat, e.hi, e.lo, e.lat);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      exp_t obs, e;
      int   gap;
      int   idle;
      issue(2'b00, '0, rnd(), rnd(), 1'b1);
      sb_q.push_back(model(op, a_hi, a_lo, b));
      wait_done(obs);
      e = sb_q.pop_front();
      checks++;
      if (obs !== e) begin
         errors++;
         $display("FAIL b2b_first got hi=%h lo=%h lat=%0d want hi=%h lo=%h lat=%0d",
                  obs.hi, obs.lo, obs.lat, e.hi, e.lo, e.lat);
      end
      gap  = 0;
      idle = 0;
      do begin
         @(posedge clk); #1;
         gap++;
         if (busy === 1'b0) idle++;
      end while ((done !== 1'b1) && (gap < TIMEOUT));
      start = 1'b0;
      checks++;
      if ((gap !== W + 2) || (idle !== 1)) begin
         errors++;
         $display("FAIL b2b_spacing got gap=%0d idle=%0d want gap=%0d idle=1", gap, idle, W + 2);
      end
      obs.hi  = hi;
      obs.lo  = lo;
      obs.ndv = ndv;
      e = sb_q.pop_front();
      checks++;
      if ((obs.hi !== e.hi) || (obs.lo !== e.lo) || (obs.ndv !== e.ndv)) begin
         errors++;
         $display("FAIL b2b_second got hi=%h lo=%h want hi=%h lo=%h", obs.hi, obs.lo, e.hi, e.lo);
      end
      @(posedge clk); #1;
      @(posedge clk); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_release busy got %b want 0", busy); end
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      a_hi  = '0;
      a_lo  = '0;
      b     = '0;
      test_reset();
      test_mul_unsigned();
      test_mul_signed();
      test_divide();
      test_reserved();
      test_reset_midrun();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
